// File: rtl/mezclador_pkg.sv
// Shared definitions for the audio mixer: voice count, track weight,
// volume range and the voice popcount helper.
package mezclador_pkg;

  localparam int NUM_NOTAS  = 12;
  localparam int PESO_PISTA = 2;
  localparam int VOL_MAX    = 15;
  localparam int SUMA_W     = 4;
  localparam int VOL_W      = 4;
  localparam int NIVEL_W    = 8;

  // Decoded volume request for one clock
  typedef enum logic [1:0] {
    VOL_MANTENER = 2'b00,
    VOL_SUBIR    = 2'b01,
    VOL_BAJAR    = 2'b10
  } vol_cmd_e;

  // Number of note waves currently high
  function automatic logic [SUMA_W-1:0] contar_notas(input logic [NUM_NOTAS-1:0] notas);
    logic [SUMA_W-1:0] total;
    total = '0;
    for (int i = 0; i < NUM_NOTAS; i++) begin
      total = total + SUMA_W'(notas[i]);
    end
    return total;
  endfunction

endpackage

// File: rtl/modulador_pwm.sv
// PWM frame generator: free-running frame counter, registered compare
// against the duty level, and the frame-start tick.
// The compare uses next-cycle counter and level so that the registered
// output in the cycle with cnt=k equals (k < level of that frame).
module modulador_pwm
  import mezclador_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NIVEL_W-1:0]  i_nivel_next,
  output logic [PWM_BITS-1:0] o_cnt,
  output logic                o_pwm,
  output logic                o_tick
);

  localparam int CMP_W = (PWM_BITS > NIVEL_W) ? PWM_BITS : NIVEL_W;

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] w_cnt_next;
  logic [CMP_W-1:0]    w_cmp_cnt;
  logic [CMP_W-1:0]    w_cmp_nivel;
  logic                r_pwm;
  logic                r_tick;

  assign w_cnt_next  = r_cnt + PWM_BITS'(1);
  assign w_cmp_cnt   = CMP_W'(w_cnt_next);
  assign w_cmp_nivel = CMP_W'(i_nivel_next);

  // Frame counter, registered duty compare and frame-start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pwm  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_pwm  <= (w_cmp_cnt < w_cmp_nivel);
      r_tick <= (r_cnt == '1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_pwm  = r_pwm;
  assign o_tick = r_tick;

endmodule

// File: rtl/mezclador_audio.sv
// Audio mixer: captures the twelve note waves (and optionally the track
// wave) once per PWM frame, counts active voices, scales by a 4-bit user
// volume and drives a single glitch-free PWM line.
// Optional feature: define MEZCLADOR_PISTA_EN to mix the track wave in
// with weight PESO_PISTA; otherwise the pista input is ignored.
module mezclador_audio
  import mezclador_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int VOL_DEFAULT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_NOTAS-1:0] onda,
  input  logic                 pista,
  input  logic                 vol_up,
  input  logic                 vol_down,
  input  logic                 mute,
  output logic                 audio_pwm,
  output logic [NIVEL_W-1:0]   nivel,
  output logic [VOL_W-1:0]     volumen,
  output logic                 sample_tick
);

`ifdef MEZCLADOR_PISTA_EN
  localparam bit PISTA_EN = 1'b1;
`else
  localparam bit PISTA_EN = 1'b0;
`endif

  // Saturating volume step; simultaneous up/down arrives as VOL_MANTENER
  function automatic logic [VOL_W-1:0] ajustar_vol(input logic [VOL_W-1:0] vol,
                                                   input vol_cmd_e          cmd);
    logic [VOL_W-1:0] res;
    res = vol;
    case (cmd)
      VOL_SUBIR: if (vol != VOL_W'(VOL_MAX)) res = vol + VOL_W'(1);
      VOL_BAJAR: if (vol != '0)              res = vol - VOL_W'(1);
      default:   res = vol;
    endcase
    return res;
  endfunction

  logic [PWM_BITS-1:0]  w_cnt;
  logic                 w_captura;
  logic                 w_carga;
  logic [NUM_NOTAS-1:0] r_cap_onda_p0;
  logic                 r_cap_pista_p0;
  logic [SUMA_W-1:0]    w_peso;
  logic [SUMA_W-1:0]    w_suma;
  logic [NIVEL_W-1:0]   w_producto;
  logic [NIVEL_W-1:0]   w_nivel_next;
  logic [NIVEL_W-1:0]   r_nivel_p1;
  logic [VOL_W-1:0]     r_vol;
  vol_cmd_e             w_cmd;

  assign w_captura = (w_cnt == {{(PWM_BITS-1){1'b1}}, 1'b0});
  assign w_carga   = (w_cnt == '1);

  // Decode the volume buttons into one request per clock
  always_comb begin
    w_cmd = VOL_MANTENER;
    case ({vol_down, vol_up})
      2'b01:   w_cmd = VOL_SUBIR;
      2'b10:   w_cmd = VOL_BAJAR;
      default: w_cmd = VOL_MANTENER;
    endcase
  end

  // Volume register, updated the clock after a button pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vol <= VOL_W'(VOL_DEFAULT);
    end else begin
      r_vol <= ajustar_vol(r_vol, w_cmd);
    end
  end

  // ---- stage p0: snapshot voices two clocks before the frame boundary ----
  // Capture voice inputs at cnt = 2^PWM_BITS-2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_onda_p0  <= '0;
      r_cap_pista_p0 <= 1'b0;
    end else if (w_captura) begin
      r_cap_onda_p0  <= onda;
      r_cap_pista_p0 <= pista & PISTA_EN;
    end
  end

  assign w_peso       = (PISTA_EN && r_cap_pista_p0) ? SUMA_W'(PESO_PISTA) : '0;
  assign w_suma       = contar_notas(r_cap_onda_p0) + w_peso;
  // Max 14 x 15 = 210, fits in 8 bits without saturation
  assign w_producto   = NIVEL_W'(w_suma) * NIVEL_W'(r_vol);
  assign w_nivel_next = w_carga ? (mute ? '0 : w_producto) : r_nivel_p1;

  // ---- stage p1: frame level, only changes at the frame boundary ----
  // Load the new duty level on the last cycle of the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nivel_p1 <= '0;
    end else begin
      r_nivel_p1 <= w_nivel_next;
    end
  end

  modulador_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_modulador (
    .clk          (clk),
    .rst          (rst),
    .i_nivel_next (w_nivel_next),
    .o_cnt        (w_cnt),
    .o_pwm        (audio_pwm),
    .o_tick       (sample_tick)
  );

  assign nivel   = r_nivel_p1;
  assign volumen = r_vol;

endmodule

// File: tb/tb_mezclador_audio.sv
// Directed bench for mezclador_audio: tracks clocks since reset release to
// know the frame position, applies voice/volume/mute/reset steps and checks
// levels, PWM duty and tick placement against hand-computed values.
module tb_mezclador_audio;

`ifdef MEZCLADOR_PISTA_EN
  localparam int S_FULL = 14;
`else
  localparam int S_FULL = 12;
`endif

  logic        clk;
  logic        rst;
  logic [11:0] onda;
  logic        pista;
  logic        vol_up;
  logic        vol_down;
  logic        mute;
  logic        audio_pwm;
  logic [7:0]  nivel;
  logic [3:0]  volumen;
  logic        sample_tick;

  int n_vec;
  int n_err;
  int K;

  mezclador_audio #(
    .PWM_BITS    (8),
    .VOL_DEFAULT (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .onda        (onda),
    .pista       (pista),
    .vol_up      (vol_up),
    .vol_down    (vol_down),
    .mute        (mute),
    .audio_pwm   (audio_pwm),
    .nivel       (nivel),
    .volumen     (volumen),
    .sample_tick (sample_tick)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      K++;
    end
  endtask

  task automatic pulse(input logic up, input logic dn, input int times);
    for (int i = 0; i < times; i++) begin
      vol_up   = up;
      vol_down = dn;
      step(1);
      vol_up   = 1'b0;
      vol_down = 1'b0;
      step(1);
    end
  endtask

  // Sample n consecutive cycles starting at the current one
  task automatic run_frame(input string tag, input int n, input int lvl, input int exp_highs);
    int highs, bad_pwm, bad_tick, bad_lvl, c;
    highs = 0; bad_pwm = 0; bad_tick = 0; bad_lvl = 0;
    for (int i = 0; i < n; i++) begin
      c = K % 256;
      if (audio_pwm === 1'b1) highs++;
      if (audio_pwm !== (c < lvl)) bad_pwm++;
      if (sample_tick !== ((c == 0) && (K != 0))) bad_tick++;
      if (nivel !== lvl[7:0]) bad_lvl++;
      step(1);
    end
    chk({tag, "_highs"}, highs, exp_highs);
    chk({tag, "_pwm_cycles_wrong"}, bad_pwm, 0);
    chk({tag, "_tick_cycles_wrong"}, bad_tick, 0);
    chk({tag, "_nivel_cycles_wrong"}, bad_lvl, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; K = 0;
    rst = 1'b1; onda = '0; pista = 1'b0;
    vol_up = 1'b0; vol_down = 1'b0; mute = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_nivel", nivel, 0);
    chk("rst_audio", audio_pwm, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_vol", volumen, 8);
    rst = 1'b0;
    K = 0;

    // Silence for four frames, tick every 256 clocks
    run_frame("silence", 1024, 0, 0);
    chk("silence_nivel_end", nivel, 0);
    chk("silence_vol", volumen, 8);

    // One voice at volume 8
    onda = 12'h001;
    step(256);
    chk("one_voice_nivel", nivel, 8);
    run_frame("one_voice", 256, 8, 8);

    // All voices plus track, volume up to saturation
    onda = 12'hFFF; pista = 1'b1;
    pulse(1'b1, 1'b0, 7);
    chk("vol_up_15", volumen, 15);
    pulse(1'b1, 1'b0, 1);
    chk("vol_up_sat", volumen, 15);
    chk("vol_mid_frame_nivel", nivel, 8);
    step(240);
    chk("full_nivel", nivel, S_FULL * 15);
    run_frame("full", 256, S_FULL * 15, S_FULL * 15);

    // Volume down to 8, then to 0 with saturation, then both buttons
    pulse(1'b0, 1'b1, 7);
    chk("vol_down_8", volumen, 8);
    pulse(1'b0, 1'b1, 10);
    chk("vol_down_sat0", volumen, 0);
    pulse(1'b1, 1'b1, 1);
    chk("vol_both_at0", volumen, 0);
    step(220);
    chk("vol0_nivel", nivel, 0);
    run_frame("vol0", 256, 0, 0);
    pulse(1'b1, 1'b0, 3);
    chk("vol_up_3", volumen, 3);
    pulse(1'b1, 1'b1, 1);
    chk("vol_both_at3", volumen, 3);

    // Mid-frame input change does not touch current level
    step(248);
    chk("vol3_nivel", nivel, S_FULL * 3);
    step(100);
    onda = 12'h00F; pista = 1'b0;
    step(1);
    chk("midframe_nivel_held", nivel, S_FULL * 3);
    step(155);
    chk("four_voice_nivel", nivel, 12);

    // Mute raised mid-frame keeps the current duty, silences the next frame
    pulse(1'b1, 1'b0, 12);
    chk("vol_up_to15", volumen, 15);
    step(232);
    chk("pre_mute_nivel", nivel, 60);
    step(50);
    mute = 1'b1;
    run_frame("mute_cur", 206, 60, 10);
    chk("mute_next_nivel", nivel, 0);
    run_frame("muted", 256, 0, 0);
    mute = 1'b0;

    // Reset in the middle of a frame with nivel = 40
    pulse(1'b0, 1'b1, 7);
    chk("vol_back_8", volumen, 8);
    onda = 12'h01F;
    step(242);
    chk("nivel_40", nivel, 40);
    pulse(1'b1, 1'b0, 1);
    chk("vol_9", volumen, 9);
    step(20);
    chk("audio_high_cnt22", audio_pwm, 1);
    step(98);
    rst = 1'b1;
    #1;
    chk("midrst_nivel", nivel, 0);
    chk("midrst_audio", audio_pwm, 0);
    chk("midrst_vol", volumen, 8);
    chk("midrst_tick", sample_tick, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    K = 0;
    run_frame("post_rst", 256, 0, 0);
    chk("post_rst_nivel", nivel, 40);
    run_frame("post_rst_40", 256, 40, 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
